// File: rtl/lmsm_sequencer_if.sv
// rtl/lmsm_sequencer_if.sv - micro-op issue bus between the LM/SM sequencer and execute
interface lmsm_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int NREG   = 8
);
    logic                      uop_valid;
    logic                      uop_ready;
    logic                      uop_is_load;
    logic [$clog2(NREG)-1:0]   uop_reg;
    logic [ADDR_W-1:0]         uop_addr;
    logic                      uop_pc_write;

    modport master (
        output uop_valid, uop_is_load, uop_reg, uop_addr, uop_pc_write,
        input  uop_ready
    );

    modport slave (
        input  uop_valid, uop_is_load, uop_reg, uop_addr, uop_pc_write,
        output uop_ready
    );
endinterface

// File: rtl/lmsm_sequencer.sv
// rtl/lmsm_sequencer.sv - expands LM/SM into ascending single-register micro-ops
module lmsm_sequencer #(
    parameter int ADDR_W = 16,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              instr_valid,
    input  logic              is_lm,
    input  logic              is_sm,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [NREG-1:0]   reg_list,
    lmsm_sequencer_if.master  uop,
    output logic              stall,
    output logic              busy,
    output logic              done
);
    localparam int IDX_W = $clog2(NREG);

    typedef enum logic [0:0] {S_IDLE, S_RUN} state_t;

    state_t            state_q, state_d;
    logic [NREG-1:0]   pending_q, pending_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              op_q, op_d;
    logic              done_q, done_d;

    logic [NREG-1:0]   low_bit;
    logic [IDX_W-1:0]  low_idx;
    logic              last;
    logic              start;

    // Priority encoder: descending scan so the lowest set bit is written last.
    always_comb begin
        low_idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (pending_q[i]) low_idx = IDX_W'(i);
        end
        low_bit = pending_q & (~pending_q + NREG'(1));
        last    = (pending_q & ~low_bit) == '0;
    end

    assign start = (state_q == S_IDLE) && instr_valid && (is_lm || is_sm) && !flush;

    always_comb begin
        state_d          = state_q;
        pending_d        = pending_q;
        addr_d           = addr_q;
        op_d             = op_q;
        done_d           = 1'b0;
        stall            = 1'b0;
        uop.uop_valid    = 1'b0;
        uop.uop_is_load  = 1'b0;
        uop.uop_reg      = '0;
        uop.uop_addr     = '0;
        uop.uop_pc_write = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pending_d = reg_list;
                    addr_d    = base_addr;
                    op_d      = is_lm;
                    if (reg_list != '0) begin
                        state_d = S_RUN;
                        stall   = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d   = S_IDLE;
                    pending_d = '0;
                end else begin
                    uop.uop_valid    = 1'b1;
                    uop.uop_is_load  = op_q;
                    uop.uop_reg      = low_idx;
                    uop.uop_addr     = addr_q;
                    uop.uop_pc_write = op_q && (low_idx == IDX_W'(NREG - 1));
                    // Decode may advance only on the final handshake.
                    stall            = !(uop.uop_ready && last);
                    if (uop.uop_ready) begin
                        pending_d = pending_q & ~low_bit;
                        addr_d    = addr_q + ADDR_W'(1);
                        if (last) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            addr_q    <= '0;
            op_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            addr_q    <= addr_d;
            op_q      <= op_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = done_q;
endmodule
